// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the PCI bus arbiter.
// Optional bus parking is enabled by defining PCI_ARB_PARK_EN.
package pci_arb_pkg;

    localparam int DEF_N_MASTERS     = 4;
    localparam int DEF_PARK_MASTER   = 0;
    localparam int DEF_GRANT_TIMEOUT = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_GAP   = 3'd1;
    localparam state_t ST_GRANT = 3'd2;
    localparam state_t ST_BUSY  = 3'd3;
    localparam state_t ST_PARK  = 3'd4;

    // Both FRAME# and IRDY# deasserted means no transaction is in flight.
    function automatic logic bus_idle(input logic frame, input logic irdy);
        return frame & irdy;
    endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin search: first low req at or above ptr, wrapping.
module pci_rr_picker #(
    parameter int N_MASTERS = 4
) (
    input  logic [N_MASTERS-1:0]         req,
    input  logic [$clog2(N_MASTERS)-1:0] ptr,
    output logic [$clog2(N_MASTERS)-1:0] winner,
    output logic                         any_req
);

    localparam int W = $clog2(N_MASTERS);

    int idx;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_MASTERS;
            if (!req[idx]) begin
                winner  = W'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with turnaround gap and unused-grant revocation.
// Define PCI_ARB_PARK_EN to park the idle bus on PARK_MASTER.
module pci_arbiter
    import pci_arb_pkg::*;
#(
    parameter int N_MASTERS     = DEF_N_MASTERS,
    parameter int PARK_MASTER   = DEF_PARK_MASTER,
    parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_MASTERS-1:0]         req,
    input  logic                         frame,
    input  logic                         irdy,
    output logic [N_MASTERS-1:0]         gnt,
    output logic [$clog2(N_MASTERS)-1:0] owner,
    output logic                         owner_vld
);

    localparam int W  = $clog2(N_MASTERS);
    localparam int TW = $clog2(GRANT_TIMEOUT + 1);

    state_t         state;
    logic [W-1:0]   ptr;
    logic [W-1:0]   winner;
    logic [W-1:0]   nextOwner;
    logic [TW-1:0]  timer;
    logic           anyReq;
    logic           idle;
    logic           grantActive;
    logic           othersReq;
    logic           timeoutHit;
    logic           leaveGrant;

    function automatic logic [N_MASTERS-1:0] lowBit(input logic [W-1:0] i);
        lowBit    = '1;
        lowBit[i] = 1'b0;
    endfunction

    pci_rr_picker #(.N_MASTERS(N_MASTERS)) uPicker (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any_req(anyReq)
    );

    assign idle        = bus_idle(frame, irdy);
    assign grantActive = ~&gnt;
    assign owner_vld   = grantActive;
    assign nextOwner   = (owner == W'(N_MASTERS - 1)) ? '0 : owner + 1'b1;
    assign othersReq   = |(~req & lowBit(owner));
    assign timeoutHit  = idle && (timer >= TW'(GRANT_TIMEOUT - 1));
    assign leaveGrant  = !frame || req[owner] || timeoutHit;

`ifdef PCI_ARB_PARK_EN
    localparam logic [W-1:0] PARK_IDX = W'(PARK_MASTER);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= '1;
            owner <= '0;
            ptr   <= '0;
            timer <= '0;
        end else begin
            // Timer only runs while sitting in GRANT; any other state holds it clear.
            if (state != ST_GRANT || leaveGrant)
                timer <= '0;
            else if (idle && timer != TW'(GRANT_TIMEOUT))
                timer <= timer + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (anyReq) begin
                        if (!grantActive) begin
                            gnt   <= lowBit(winner);
                            owner <= winner;
                            state <= ST_GRANT;
                        end else if (winner == owner) begin
                            state <= ST_GRANT;
                        end else begin
                            gnt   <= '1;
                            state <= ST_GAP;
                        end
                    end else begin
`ifdef PCI_ARB_PARK_EN
                        // A leftover grant to someone else needs a gap before parking.
                        if (grantActive && owner != PARK_IDX) begin
                            gnt   <= '1;
                            state <= ST_GAP;
                        end else begin
                            gnt   <= lowBit(PARK_IDX);
                            owner <= PARK_IDX;
                            state <= ST_PARK;
                        end
`else
                        gnt <= '1;
`endif
                    end
                end
                ST_GAP: state <= ST_IDLE;
                ST_GRANT: begin
                    if (!frame) begin
                        state <= ST_BUSY;
                        ptr   <= nextOwner;
                    end else if (req[owner]) begin
                        gnt   <= '1;
                        state <= ST_GAP;
                    end else if (timeoutHit) begin
                        gnt   <= '1;
                        ptr   <= nextOwner;
                        state <= ST_GAP;
                    end
                end
                ST_BUSY: begin
                    // Early grant removal only hints; the owner completes its burst.
                    if (othersReq) gnt <= '1;
                    if (idle) state <= ST_IDLE;
                end
`ifdef PCI_ARB_PARK_EN
                ST_PARK: if (anyReq) state <= ST_IDLE;
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pci_arbiter.md
# pci_arbiter

Central PCI bus arbiter for the slave test system. It shares the PCI bus among up to `N_MASTERS` initiators using active-low `req`/`gnt` pairs, and grants in round-robin order. It watches `frame` and `irdy` to track bus ownership, enforces a one-cycle turnaround gap between grants, and revokes grants that go unused. It sits beside the target-side blocks (decoder, DEVSEL# generator) and feeds the same `frame`/`irdy` bus lines they observe.

## Interface
- `N_MASTERS`, default 4: number of requesters (2..8).
- `PARK_MASTER`, default 0: index granted when the bus is parked (only with `PCI_ARB_PARK_EN`).
- `GRANT_TIMEOUT`, default 16: idle-bus clocks a granted master may leave `frame` high before its grant is revoked.

Ports:
- `clk` in 1: bus clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in `N_MASTERS`: per-master request, active low.
- `frame` in 1: PCI FRAME#, active low.
- `irdy` in 1: PCI IRDY#, active low.
- `gnt` out `N_MASTERS`: per-master grant, active low, registered.
- `owner` out `$clog2(N_MASTERS)`: index of the current or last granted master, registered.
- `owner_vld` out 1: high while any `gnt` bit is low.

## Operation
- Bus idle is `frame==1 && irdy==1`, sampled at `posedge clk`.
- Winner selection:
  - The winner is the first index with `req==0`, searching upward from `ptr` and wrapping modulo `N_MASTERS`.
  - `ptr` resets to 0.
  - When a transaction starts or a grant is revoked, `ptr` becomes owner+1 (mod `N_MASTERS`).
- At most one `gnt` bit is low at any time.
- **IDLE**
  - No request: go to PARK (with macro); otherwise hold `gnt` all ones.
  - Request present and no grant active: drive `gnt[winner]`=0, set owner=winner, go to GRANT.
  - Request present, a parked grant is active, and winner == parked master: keep the grant and go to GRANT.
  - Request present, a parked grant is active, and winner differs: drive `gnt` all ones and go to GAP.
- **GAP**
  - All grants deasserted for exactly one cycle, then go to IDLE.
- **GRANT**
  - The timer counts clocks with the bus idle.
  - `frame==0` sampled: go to BUSY and advance `ptr`.
  - `req[owner]` returns high before `frame` falls: deassert the grant and go to GAP. `ptr` is unchanged.
  - Timer reaches `GRANT_TIMEOUT` with `frame` still high: deassert the grant, advance `ptr`, go to GAP.
- **BUSY**
  - Owner holds the bus.
  - If any other `req` is low, drive `gnt[owner]`=1 on the next clock. This is the preemption hint; the owner still finishes its transaction.
  - When the bus returns to idle, go to IDLE and re-arbitrate.
- **PARK** (macro only)
  - `gnt[PARK_MASTER]`=0 with the bus idle and no requests.
  - Any request moves the FSM to IDLE in the next cycle; the parked grant is handled as described under IDLE.
- Timer width is `$clog2(GRANT_TIMEOUT+1)`. It clears on every state entry and saturates at `GRANT_TIMEOUT`.

## Timing
- Reset values:
  - `gnt` all ones.
  - `owner`=0, `owner_vld`=0.
  - State IDLE, `ptr`=0, timer=0.
- Reset is honoured mid-transaction: grants drop asynchronously, with no gap cycle required.
- Latency from `req` falling on an idle, ungranted bus to `gnt` low: 1 clock (sampled edge N, `gnt` low after edge N+1).
- Switching from one grant to another on an idle bus always takes 1 all-ones cycle (GAP), so the new `gnt` is low 2 clocks after the old one rises.
- `frame` falling in the same cycle as the timeout: frame wins, go to BUSY.
- `req[owner]` rising in the same cycle as `frame` falling: go to BUSY.
- Requests arriving during BUSY do not alter `owner` until the bus goes idle.

## Configuration
- `PCI_ARB_PARK_EN` defined:
  - The PARK state exists; the bus is parked on `PARK_MASTER` whenever idle with no requests.
  - Reset exit goes IDLE→PARK after one cycle.
- `PCI_ARB_PARK_EN` undefined:
  - There is no PARK state, and `PARK_MASTER` is ignored.
  - `gnt` stays all ones when there are no requests.

## Structure
- `pci_arb_pkg`: state enum (IDLE, GAP, GRANT, BUSY, PARK), `bus_idle` helper function, default parameter constants.
- Sub-module `pci_rr_picker`: combinational round-robin priority search. It takes `req`, `ptr` and returns `winner` and `any_req`; it is instantiated once.

## Test plan
- Reset with `req`=4'b1111, no macro → `gnt`=4'b1111 and `owner_vld`=0 for all cycles.
- `req`=4'b1110, then master 0 drops `frame` 2 clocks after its grant → `gnt`=4'b1110 one clock after `req`, BUSY; on bus idle `ptr`=1.
- `req`=4'b0101 (masters 1 and 3) from `ptr`=0 → grant 1; after its transaction ends, grant 3 following one all-ones GAP cycle.
- Granted master never asserts `frame` → `gnt` returns to 4'b1111 after 16 idle clocks, then the next requester is granted.
- During master 2's burst, `req[0]` falls → `gnt[2]` rises next clock, `frame` continues; `gnt`=4'b1110 two clocks after the bus goes idle.
- `PCI_ARB_PARK_EN`, `PARK_MASTER`=0, `req`=4'b1011 arrives while parked → `gnt` 4'b1110 → 4'b1111 (GAP) → 4'b1011.
